// File: rtl/bitmap_pkg.sv
// Shared types and defaults for the bitmap memory arbiter: FSM state encoding,
// pixel word type and the address range helper used by the CPU and display paths.
package bitmap_pkg;

    localparam int BM_ADDR_W = 12;
    localparam int BM_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bm_arb_state_t;

    // 4-bit R, G and B packed into one word
    typedef logic [BM_DATA_W-1:0] pixel_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/bitmap_starve_cnt.sv
// Counts cycles a pending CPU access is held off by the display and raises a
// sticky starvation flag once the count reaches LIMIT; only reset clears the flag.
module bitmap_starve_cnt #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic starved
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved_q, starved_d;

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
        starved_d = starved_q | (cnt_d == LIMIT_C);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            starved_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            starved_q <= starved_d;
        end
    end

    assign starved = starved_q;

endmodule

// File: rtl/bitmap_mem_arbiter.sv
// Shares the single bitmap memory port between the display pipeline (always wins)
// and the CPU, whose req/ack accesses are slotted into display-idle cycles.
module bitmap_mem_arbiter
    import bitmap_pkg::*;
#(
    parameter int ADDR_W       = BM_ADDR_W,
    parameter int DATA_W       = BM_DATA_W,
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_color,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    bm_arb_state_t     state_q, state_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] disp_color_q, disp_color_d;
    logic              disp_valid_q, disp_valid_d;

    logic cpu_access;
    logic op_in_range;
    logic disp_in_range;
    logic cnt_clear;
    logic cnt_inc;

    assign op_in_range   = addr_in_range(32'(op_addr_q), DEPTH);
    assign disp_in_range = addr_in_range(32'(disp_addr), DEPTH);

    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_access  = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    op_we_d    = cpu_we;
                    op_addr_d  = cpu_addr;
                    op_wdata_d = cpu_wdata;
                    cnt_clear  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (disp_req) begin
                    cnt_inc = 1'b1;
                end else begin
                    cpu_access  = 1'b1;
                    cpu_rdata_d = (!op_we_q && op_in_range) ? mem_rdata : '0;
                    state_d     = ACK;
                end
            end
            ACK: begin
                // cpu_req is deliberately not looked at until we are back in IDLE
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display owns the port whenever it asks; the CPU op only drives it in a free WAIT cycle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp_req) begin
            mem_addr = disp_addr;
        end else if (cpu_access) begin
            mem_addr  = op_addr_q;
            mem_we    = op_we_q && op_in_range;
            mem_wdata = op_wdata_q;
        end
    end

    always_comb begin
        disp_valid_d = disp_req;
        disp_color_d = disp_color_q;
        if (disp_req) begin
            disp_color_d = disp_in_range ? mem_rdata : '0;
        end
    end

    // State reset to IDLE removes cpu_access at once, so a half-done write never lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_we_q      <= 1'b0;
            op_addr_q    <= '0;
            op_wdata_q   <= '0;
            cpu_rdata_q  <= '0;
            disp_color_q <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_we_q      <= op_we_d;
            op_addr_q    <= op_addr_d;
            op_wdata_q   <= op_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            disp_color_q <= disp_color_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    bitmap_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .starved (cpu_starved)
    );

    assign cpu_ack    = (state_q == ACK);
    assign cpu_rdata  = cpu_rdata_q;
    assign disp_color = disp_color_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_bitmap_mem_arbiter.sv
// Directed bench for bitmap_mem_arbiter: a display read table plus hand-written
// CPU access, starvation, out-of-range and reset sequences against a bench memory.
module tb_bitmap_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic [11:0] disp_color;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_ack;
    logic [11:0] cpu_rdata;
    logic        cpu_starved;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    logic [11:0] tb_mem [4096];
    logic        mem_init_done = 1'b0;
    int          wr_count = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitmap_mem_arbiter #(
        .ADDR_W       (12),
        .DATA_W       (12),
        .DEPTH        (1024),
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_color  (disp_color),
        .disp_valid  (disp_valid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_starved (cpu_starved),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Bitmap memory: combinational read, synchronous write, preloaded on the first edge.
    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) tb_mem[i] <= 12'h000;
            tb_mem[12'h001] <= 12'h123;
            tb_mem[12'h005] <= 12'h5A5;
            tb_mem[12'h030] <= 12'h111;
            tb_mem[12'h0FF] <= 12'h0F0;
            tb_mem[12'h3FF] <= 12'hABC;
            tb_mem[12'h400] <= 12'h777;
            mem_init_done   <= 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            wr_count         <= wr_count + 1;
        end
    end

    typedef struct {
        logic        req;
        logic [11:0] addr;
        logic [11:0] exp_mem_addr;
        logic [11:0] exp_color;
        logic        exp_valid;
    } disp_vec_t;

    disp_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_raise(input logic we, input logic [11:0] addr, input logic [11:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    initial begin
        int w0;
        int err;

        vecs[0] = '{1'b1, 12'h001, 12'h001, 12'h123, 1'b1};
        vecs[1] = '{1'b1, 12'h3FF, 12'h3FF, 12'hABC, 1'b1};
        vecs[2] = '{1'b0, 12'h3FF, 12'h000, 12'hABC, 1'b0};
        vecs[3] = '{1'b1, 12'h400, 12'h400, 12'h000, 1'b1};
        vecs[4] = '{1'b1, 12'h0FF, 12'h0FF, 12'h0F0, 1'b1};
        vecs[5] = '{1'b0, 12'h001, 12'h000, 12'h0F0, 1'b0};

        reset     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = 12'h000;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 12'h000;
        cpu_wdata = 12'h000;
        tick();
        tick();

        check("rst_disp_color", disp_color, 12'h000);
        check("rst_disp_valid", disp_valid, 1'b0);
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 12'h000);
        check("rst_cpu_starved", cpu_starved, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 12'h000);
        reset = 1'b0;
        tick();

        // Display read table
        for (int i = 0; i < 6; i++) begin
            disp_req  = vecs[i].req;
            disp_addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_mem_addr);
            check($sformatf("vec%0d_mem_we", i), mem_we, 1'b0);
            tick();
            check($sformatf("vec%0d_disp_color", i), disp_color, vecs[i].exp_color);
            check($sformatf("vec%0d_disp_valid", i), disp_valid, vecs[i].exp_valid);
        end
        disp_req = 1'b0;

        // T2: CPU write with display idle, then display reads it back
        w0 = wr_count;
        cpu_raise(1'b1, 12'h010, 12'hF00);
        #1;
        check("t2_idle_mem_we", mem_we, 1'b0);
        tick();
        check("t2_access_mem_we", mem_we, 1'b1);
        check("t2_access_mem_addr", mem_addr, 12'h010);
        check("t2_access_mem_wdata", mem_wdata, 12'hF00);
        check("t2_access_no_ack", cpu_ack, 1'b0);
        tick();
        check("t2_ack", cpu_ack, 1'b1);
        check("t2_ack_mem_we", mem_we, 1'b0);
        check("t2_mem_word", tb_mem[12'h010], 12'hF00);
        check("t2_write_count", wr_count, w0 + 1);
        cpu_req   = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        tick();
        check("t2_disp_color", disp_color, 12'hF00);
        check("t2_disp_valid", disp_valid, 1'b1);
        check("t2_ack_drop", cpu_ack, 1'b0);
        disp_req = 1'b0;

        // T6: back-to-back writes, req re-raised the cycle after ack
        w0 = wr_count;
        cpu_raise(1'b1, 12'h020, 12'h0A5);
        tick();
        tick();
        check("t6_first_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        check("t6_ack_gap", cpu_ack, 1'b0);
        cpu_raise(1'b1, 12'h021, 12'h0B6);
        tick();
        check("t6_second_mem_we", mem_we, 1'b1);
        check("t6_second_no_ack", cpu_ack, 1'b0);
        tick();
        check("t6_second_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        check("t6_write_count", wr_count, w0 + 2);
        check("t6_word0", tb_mem[12'h020], 12'h0A5);
        check("t6_word1", tb_mem[12'h021], 12'h0B6);

        // T5: out-of-range write suppressed but acked; out-of-range read returns 0
        w0 = wr_count;
        cpu_raise(1'b1, 12'h400, 12'hFFF);
        tick();
        check("t5_wr_mem_we", mem_we, 1'b0);
        tick();
        check("t5_wr_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        check("t5_wr_count", wr_count, w0);
        check("t5_wr_word", tb_mem[12'h400], 12'h777);
        cpu_raise(1'b0, 12'h400, 12'h000);
        tick();
        tick();
        check("t5_rd_ack", cpu_ack, 1'b1);
        check("t5_rd_data", cpu_rdata, 12'h000);
        cpu_req = 1'b0;
        tick();

        // T3: display busy for 20 cycles while a CPU read waits
        err = 0;
        disp_req = 1'b1;
        cpu_raise(1'b0, 12'h005, 12'h000);
        for (int i = 0; i < 20; i++) begin
            disp_addr = 12'(i + 12'h100);
            #1;
            if (mem_addr !== disp_addr || mem_we !== 1'b0 || cpu_ack !== 1'b0) err++;
            tick();
            if (disp_valid !== 1'b1) err++;
        end
        check("t3_busy_errors", err, 0);
        disp_req = 1'b0;
        #1;
        check("t3_access_mem_addr", mem_addr, 12'h005);
        check("t3_access_no_ack", cpu_ack, 1'b0);
        tick();
        check("t3_ack", cpu_ack, 1'b1);
        check("t3_rdata", cpu_rdata, 12'h5A5);
        cpu_req = 1'b0;
        tick();
        check("t3_starved", cpu_starved, 1'b1);

        // T4: starvation flag at wait count 8 with STARVE_LIMIT=8, sticky until reset
        reset = 1'b1;
        #1;
        check("t4_reset_clears_starved", cpu_starved, 1'b0);
        reset = 1'b0;
        tick();
        disp_req  = 1'b1;
        disp_addr = 12'h001;
        cpu_raise(1'b0, 12'h005, 12'h000);
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t4_starved_cnt%0d", k), cpu_starved, (k >= 8) ? 1'b1 : 1'b0);
        end
        disp_req = 1'b0;
        tick();
        check("t4_ack", cpu_ack, 1'b1);
        check("t4_starved_at_ack", cpu_starved, 1'b1);
        cpu_req = 1'b0;
        tick();
        tick();
        check("t4_starved_sticky", cpu_starved, 1'b1);

        // T1: reset while a write is being driven onto the memory port
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        w0 = wr_count;
        disp_req  = 1'b1;
        disp_addr = 12'h001;
        cpu_raise(1'b1, 12'h030, 12'h555);
        tick();
        tick();
        check("t1_held_mem_we", mem_we, 1'b0);
        disp_req = 1'b0;
        #1;
        check("t1_pending_mem_we", mem_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t1_rst_mem_we", mem_we, 1'b0);
        check("t1_rst_ack", cpu_ack, 1'b0);
        check("t1_rst_disp_valid", disp_valid, 1'b0);
        check("t1_rst_disp_color", disp_color, 12'h000);
        check("t1_rst_rdata", cpu_rdata, 12'h000);
        check("t1_rst_starved", cpu_starved, 1'b0);
        cpu_req = 1'b0;
        tick();
        tick();
        check("t1_word_unchanged", tb_mem[12'h030], 12'h111);
        check("t1_no_write", wr_count, w0);
        check("t1_no_ack", cpu_ack, 1'b0);
        reset = 1'b0;
        tick();
        check("t1_idle_after_reset", cpu_ack, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
